l2_bank_bist_master: RTL and testbench
======================================

# l2_bank_bist_master

Initiator side of the UNICAD_MEM_BUS_32 bank interface. It drives one L2 bank port (interleaved or private) to fill the bank with an address-tagged pattern and/or read it back and check it. It serves boot-time memory initialisation and production/self-test. Integration places it in front of the bank behind a 2:1 mux that selects this block while `busy_o` is high.

## Interface
Parameters:
- `ADDR_WIDTH`, default 14: bank word-address width.
- `NB_WORDS`, default 16384: words tested, addresses 0..NB_WORDS-1; must satisfy 2 ≤ NB_WORDS ≤ 2**ADDR_WIDTH.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: sampled only in IDLE; launches a run.
- `abort_i` in 1: terminates a run.
- `mode_i` in 2: 00 fill; 01 check; 10 and 11 fill-then-check. Latched at start.
- `pattern_i` in 32: base pattern, latched at start.
- `busy_o` out 1: run in progress; bank owned by this block.
- `done_o` out 1: one-cycle pulse at normal completion.
- `error_o` out 1: sticky mismatch flag.
- `err_addr_o` out ADDR_WIDTH: address of the first mismatch.
- `err_cnt_o` out 16: saturating mismatch count.
- `mem_csn_o` out 1: chip select, active-low.
- `mem_wen_o` out 1: write enable, active-low.
- `mem_be_o` out 4: byte enable, active-high.
- `mem_add_o` out ADDR_WIDTH: word address.
- `mem_wdata_o` out 32: write data.
- `mem_rdata_i` in 32: read data, valid the cycle after a read access.

## Operation
- Expected or written word at address A: latched pattern XOR zero-extended A.
- FSM states and transitions:
  - IDLE → WRITE on start with a fill mode; IDLE → READ on start with mode 01.
  - WRITE → READ after the last write when the mode is 10/11; WRITE → DONE after the last write when the mode is 00.
  - READ → DRAIN after the last read.
  - DRAIN → DONE.
  - DONE → IDLE.
- WRITE issues one full-word write per cycle (csn=0, wen=0, be=4'hF), addresses ascending from 0.
- READ issues one read per cycle (csn=0, wen=1, be=4'hF). The address and expected data are pipelined one stage and compared against `mem_rdata_i` on the following cycle.
- DRAIN: no access; it performs the compare for the final read.
- A start accepted in IDLE clears `error_o`, `err_addr_o` and `err_cnt_o`.
- On each mismatch:
  - `err_cnt_o` increments, saturating at 16'hFFFF.
  - `error_o` sets.
  - `err_addr_o` captures the address only on the first mismatch of the run.
- `start_i` is ignored outside IDLE.
- `abort_i` in any state other than IDLE forces IDLE on the next edge. There is no `done_o` pulse, any in-flight compare is discarded, and error outputs keep their values. `abort_i` takes priority over all other transitions.
- The address counter never wraps: the last access is NB_WORDS-1 and the counter returns to 0 on phase change.

## Timing
- All `mem_*` outputs, `busy_o` and `done_o` are registered.
- Cycle numbering: start is sampled at edge 0; cycle k is the cycle after edge k-1.
- Fill mode:
  - Writes in cycles 1..N.
  - `done_o` in cycle N+1.
- Check mode:
  - Reads in cycles 1..N.
  - DRAIN in cycle N+1.
  - `done_o` in cycle N+2.
- Fill-then-check mode:
  - Writes in cycles 1..N.
  - Reads in cycles N+1..2N, with no bubble at the phase change.
  - DRAIN in cycle 2N+1.
  - `done_o` in cycle 2N+2.
- `busy_o` is high from cycle 1 through the DONE cycle inclusive.
- `mem_csn_o` is 1 in IDLE, DRAIN and DONE.
- After abort sampled at edge k: `mem_csn_o`=1 and `busy_o`=0 in cycle k+1.
- A start sampled in the DONE cycle is ignored; a new start is accepted from the first IDLE cycle.
- Reset values: `mem_csn_o`=1, `mem_wen_o`=1, `mem_be_o`=0, `mem_add_o`=0, `mem_wdata_o`=0, `busy_o`=0, `done_o`=0, `error_o`=0, `err_addr_o`=0, `err_cnt_o`=0; FSM in IDLE.
- Reset mid-run returns to these values immediately (asynchronous).

## Structure
- Package `l2_bist_pkg`:
  - FSM state enum (IDLE, WRITE, READ, DRAIN, DONE).
  - Mode constants (MODE_FILL=2'b00, MODE_CHECK=2'b01, MODE_FILL_CHECK=2'b10).
  - Error counter width constant (16).
- Sub-module `l2_bist_checker` holds:
  - the one-stage expected-data/address pipeline;
  - the comparator;
  - the first-address capture;
  - the saturating counter.
- Its inputs are `cmp_valid`, `exp_addr`, `exp_data`, `rdata`, `clear` and `flush`.
- The top level holds the FSM, the address counter and the bus drive.

## Test plan
- NB_WORDS=16, mode 00, pattern 32'hA5A5_0000, start → 16 writes in cycles 1..16, address 3 written with 32'hA5A5_0003, `done_o` in cycle 17, `error_o`=0.
- Mode 10 against a behavioural 1-cycle-latency RAM, pattern 32'hFFFF_FFFF → reads in cycles 17..32, `done_o` in cycle 34, `err_cnt_o`=0.
- Same as the previous scenario with the RAM model corrupting bit 0 at addresses 5 and 9 → `error_o`=1, `err_addr_o`=5, `err_cnt_o`=2.
- Mode 01 on a RAM with all locations corrupted, NB_WORDS=2**ADDR_WIDTH for a small ADDR_WIDTH, plus a forced 16'hFFFE preload variant → `err_cnt_o` saturates at 16'hFFFF without wrapping.
- `abort_i` in cycle 6 of a fill → `mem_csn_o`=1 and `busy_o`=0 in cycle 7, no `done_o` pulse.
- `start_i` pulsed again during a run → ignored.
- `rst_ni` asserted mid-READ → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/l2_bist_pkg.sv
// Shared types and constants for the L2 bank BIST master and its read-back checker.
package l2_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam logic [1:0] MODE_FILL       = 2'b00;
  localparam logic [1:0] MODE_CHECK      = 2'b01;
  localparam logic [1:0] MODE_FILL_CHECK = 2'b10;

  localparam int unsigned ErrCntWidth = 16;

  // Address-tagged word: the base pattern XOR the zero-extended word address.
  function automatic logic [31:0] tag_word(logic [31:0] pattern, logic [31:0] addr);
    return pattern ^ addr;
  endfunction

endpackage

// File: rtl/l2_bist_checker.sv
// Read-back checker: one-stage expected-data pipeline, comparator, first-fail address
// capture and saturating mismatch counter.
module l2_bist_checker
  import l2_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmp_valid_i,
  input  logic [ADDR_WIDTH-1:0]  exp_addr_i,
  input  logic [31:0]            exp_data_i,
  input  logic [31:0]            rdata_i,
  input  logic                   clear_i,
  input  logic                   flush_i,
  output logic                   error_o,
  output logic [ADDR_WIDTH-1:0]  err_addr_o,
  output logic [ErrCntWidth-1:0] err_cnt_o
);

  logic                   vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic                   error_q, error_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic                   mismatch;

  // A flush discards both the compare due this cycle and the read just issued.
  assign mismatch = vld_q & ~flush_i & (rdata_i != data_q);

  always_comb begin
    vld_d      = cmp_valid_i & ~flush_i;
    addr_d     = cmp_valid_i ? exp_addr_i : addr_q;
    data_d     = cmp_valid_i ? exp_data_i : data_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (clear_i) begin
      error_d    = 1'b0;
      err_addr_d = '0;
      err_cnt_d  = '0;
    end else if (mismatch) begin
      error_d = 1'b1;
      if (!error_q) err_addr_d = addr_q;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ErrCntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign error_o    = error_q;
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: rtl/l2_bank_bist_master.sv
// BIST initiator for one L2 bank port: fills the bank with an address-tagged pattern
// and/or reads it back through the checker.
module l2_bank_bist_master
  import l2_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned NB_WORDS   = 16384
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [1:0]             mode_i,
  input  logic [31:0]            pattern_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [ADDR_WIDTH-1:0]  err_addr_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic                   mem_csn_o,
  output logic                   mem_wen_o,
  output logic [3:0]             mem_be_o,
  output logic [ADDR_WIDTH-1:0]  mem_add_o,
  output logic [31:0]            mem_wdata_o,
  input  logic [31:0]            mem_rdata_i
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NB_WORDS - 1);

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [31:0]           pattern_q, pattern_d;
  logic                  csn_q, csn_d, wen_q, wen_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]            be_q, be_d;
  logic [ADDR_WIDTH-1:0] add_q, add_d, add_inc;
  logic [31:0]           wdata_q, wdata_d;
  logic                  last_addr, start_acc, abort_acc;

  assign last_addr = (add_q == LastAddr);
  assign add_inc   = add_q + ADDR_WIDTH'(1);
  assign start_acc = (state_q == StIdle) & start_i;
  assign abort_acc = (state_q != StIdle) & abort_i;

  // The bus registers double as the address counter: add_q is the word on the bus now.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    csn_d     = 1'b1;
    wen_d     = 1'b1;
    be_d      = 4'h0;
    add_d     = '0;
    wdata_d   = '0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    if (abort_acc) begin
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          busy_d = 1'b0;
          if (start_i) begin
            mode_d    = mode_i;
            pattern_d = pattern_i;
            busy_d    = 1'b1;
            csn_d     = 1'b0;
            be_d      = 4'hF;
            if (mode_i == MODE_CHECK) begin
              state_d = StRead;
            end else begin
              state_d = StWrite;
              wen_d   = 1'b0;
              wdata_d = tag_word(pattern_i, 32'd0);
            end
          end
        end
        StWrite: begin
          if (!last_addr) begin
            csn_d   = 1'b0;
            wen_d   = 1'b0;
            be_d    = 4'hF;
            add_d   = add_inc;
            wdata_d = tag_word(pattern_q, 32'(add_inc));
          end else if (mode_q == MODE_FILL) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StRead;
            csn_d   = 1'b0;
            be_d    = 4'hF;
          end
        end
        StRead: begin
          if (!last_addr) begin
            csn_d = 1'b0;
            be_d  = 4'hF;
            add_d = add_inc;
          end else begin
            state_d = StDrain;
          end
        end
        StDrain: begin
          state_d = StDone;
          done_d  = 1'b1;
        end
        StDone: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      mode_q    <= MODE_FILL;
      pattern_q <= '0;
      csn_q     <= 1'b1;
      wen_q     <= 1'b1;
      be_q      <= 4'h0;
      add_q     <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      csn_q     <= csn_d;
      wen_q     <= wen_d;
      be_q      <= be_d;
      add_q     <= add_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  l2_bist_checker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_checker (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmp_valid_i (~csn_q & wen_q),
    .exp_addr_i  (add_q),
    .exp_data_i  (tag_word(pattern_q, 32'(add_q))),
    .rdata_i     (mem_rdata_i),
    .clear_i     (start_acc),
    .flush_i     (abort_acc),
    .error_o     (error_o),
    .err_addr_o  (err_addr_o),
    .err_cnt_o   (err_cnt_o)
  );

  assign mem_csn_o   = csn_q;
  assign mem_wen_o   = wen_q;
  assign mem_be_o    = be_q;
  assign mem_add_o   = add_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_l2_bank_bist_master.sv
// Scoreboard bench for l2_bank_bist_master: a reference model queues expected bus
// accesses and completion status; a monitor pops and compares as the DUT presents them.
module tb_l2_bank_bist_master;
  import l2_bist_pkg::*;

  localparam int unsigned AW    = 6;
  localparam int unsigned NW    = 16;
  localparam int unsigned BigAw = 16;
  localparam int unsigned BigNw = 65536;

  typedef struct {
    int              cyc;
    logic            wen;
    logic [AW-1:0]   addr;
    logic [31:0]     wdata;
  } acc_t;

  typedef struct {
    int              cyc;
    logic            err;
    logic [AW-1:0]   addr;
    logic [15:0]     cnt;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0, abort_i = 1'b0;
  logic [1:0]    mode_i = 2'b00;
  logic [31:0]   pattern_i = 32'h0;
  logic          busy_o, done_o, error_o;
  logic [AW-1:0] err_addr_o;
  logic [15:0]   err_cnt_o;
  logic          mem_csn, mem_wen;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_add;
  logic [31:0]   mem_wdata, mem_rdata;

  logic             big_rst_n = 1'b0, big_start = 1'b0, big_fin = 1'b0;
  logic             big_busy, big_done, big_error, big_csn, big_wen;
  logic [BigAw-1:0] big_err_addr, big_add;
  logic [15:0]      big_err_cnt;
  logic [3:0]       big_be;
  logic [31:0]      big_wdata;

  acc_t acc_q[$];
  res_t res_q[$];
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0;

  logic [31:0]      ram [2**AW];
  logic [2**AW-1:0] corrupt = '0;
  logic             preload_req = 1'b0;
  logic [31:0]      preload_pat = 32'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_bank_bist_master #(.ADDR_WIDTH(AW), .NB_WORDS(NW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
    .pattern_i(pattern_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o), .mem_csn_o(mem_csn), .mem_wen_o(mem_wen),
    .mem_be_o(mem_be), .mem_add_o(mem_add), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Full address space, every read wrong: exercises counter saturation.
  l2_bank_bist_master #(.ADDR_WIDTH(BigAw), .NB_WORDS(BigNw)) dut_big (
    .clk_i(clk), .rst_ni(big_rst_n), .start_i(big_start), .abort_i(1'b0),
    .mode_i(MODE_CHECK), .pattern_i(32'h0), .busy_o(big_busy), .done_o(big_done),
    .error_o(big_error), .err_addr_o(big_err_addr), .err_cnt_o(big_err_cnt),
    .mem_csn_o(big_csn), .mem_wen_o(big_wen), .mem_be_o(big_be), .mem_add_o(big_add),
    .mem_wdata_o(big_wdata), .mem_rdata_i(32'hFFFF_0000)
  );

  // Behavioural 1-cycle-latency RAM with per-address bit-0 corruption on read.
  always @(posedge clk) begin
    if (preload_req) begin
      for (int a = 0; a < 2**AW; a++) ram[a] <= preload_pat ^ 32'(a);
    end else if (!mem_csn) begin
      if (!mem_wen) ram[mem_add] <= mem_wdata;
      else mem_rdata <= ram[mem_add] ^ {31'h0, corrupt[mem_add]};
    end
  end

  task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    if (act !== req) fail_now(name, act, req);
    else n_cmp++;
  endtask

  always @(negedge clk) begin : monitor
    acc_t ea;
    res_t er;
    if (rst_ni) begin
      if (!mem_csn) begin
        if (acc_q.size() == 0) begin
          fail_now("unexpected_access", 64'(mem_add), 64'(cyc));
        end else begin
          ea = acc_q.pop_front();
          check("acc_cycle", 64'(cyc), 64'(ea.cyc));
          check("acc_bus", 64'({busy_o, mem_wen, mem_be, mem_add, mem_wen ? 32'h0 : mem_wdata}),
                64'({1'b1, ea.wen, 4'hF, ea.addr, ea.wdata}));
        end
      end
      if (done_o) begin
        if (res_q.size() == 0) begin
          fail_now("unexpected_done", 64'(cyc), 64'(0));
        end else begin
          er = res_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(er.cyc));
          check("done_status", 64'({busy_o, mem_csn, error_o, err_addr_o, err_cnt_o}),
                64'({1'b1, 1'b1, er.err, er.addr, er.cnt}));
        end
      end
    end
  end

  // Reference model: the whole run's bus traffic and final status from the rules.
  task automatic launch(input logic [1:0] mode, input logic [31:0] pat, input int abort_cyc,
                        output int e0);
    bit          fill, chk, err;
    int          j, lim;
    logic [AW-1:0] first;
    logic [15:0] cnt;
    fill = (mode != MODE_CHECK);
    chk  = (mode != MODE_FILL);
    if (mode == MODE_CHECK) begin
      preload_pat = pat;
      @(negedge clk) preload_req = 1'b1;
      @(negedge clk) preload_req = 1'b0;
    end
    @(negedge clk);
    mode_i = mode;
    pattern_i = pat;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    e0  = cyc;
    j   = 0;
    lim = (abort_cyc == 0) ? 32'h4000_0000 : abort_cyc;
    if (fill) for (int a = 0; a < NW; a++) begin
      if (j < lim) acc_q.push_back('{e0 + j, 1'b0, AW'(a), pat ^ 32'(a)});
      j++;
    end
    if (chk) for (int a = 0; a < NW; a++) begin
      if (j < lim) acc_q.push_back('{e0 + j, 1'b1, AW'(a), 32'h0});
      j++;
    end
    err = 1'b0;
    first = '0;
    cnt = 16'h0;
    if (chk) for (int a = 0; a < NW; a++) begin
      if (corrupt[a]) begin
        if (!err) first = AW'(a);
        err = 1'b1;
        if (cnt != 16'hFFFF) cnt++;
      end
    end
    if (abort_cyc == 0) res_q.push_back('{chk ? e0 + j + 1 : e0 + j, err, first, cnt});
  endtask

  task automatic wait_done(input bit mid_start, input bit start_in_done);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * NW + 10 && !seen; i++) begin
      @(negedge clk);
      start_i = mid_start && (i == 3);
      if (mid_start && i == 3) begin
        mode_i = ~mode_i;
        pattern_i = ~pattern_i;
      end
      seen = done_o;
    end
    start_i = 1'b0;
    if (!seen) begin
      fail_now("done_timeout", 64'(cyc), 64'(0));
    end else if (start_in_done) begin
      mode_i = MODE_FILL;
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("acc_queue_left", 64'(acc_q.size()), 64'(0));
    check("res_queue_left", 64'(res_q.size()), 64'(0));
    check("idle_after_run", 64'({busy_o, mem_csn}), 64'({1'b0, 1'b1}));
  endtask

  initial begin : big_run
    int  e0;
    bit  seen = 1'b0;
    #23 big_rst_n = 1'b1;
    @(negedge clk) big_start = 1'b1;
    @(posedge clk);
    #1 big_start = 1'b0;
    e0 = cyc;
    for (int i = 0; i < BigNw + 10 && !seen; i++) begin
      @(negedge clk);
      seen = big_done;
    end
    if (!seen) begin
      fail_now("big_done_timeout", 64'(cyc), 64'(e0 + BigNw + 1));
    end else begin
      check("big_done_cycle", 64'(cyc), 64'(e0 + BigNw + 1));
      check("big_err_sat", 64'({big_busy, big_csn, big_error, big_err_addr, big_err_cnt}),
            64'({1'b1, 1'b1, 1'b1, 16'h0, 16'hFFFF}));
    end
    big_fin = 1'b1;
  end

  initial begin : main
    int e0;
    repeat (3) @(negedge clk);
    check("reset_bus", 64'({mem_csn, mem_wen, mem_be, mem_add, mem_wdata}),
          64'({1'b1, 1'b1, 4'h0, AW'(0), 32'h0}));
    check("reset_status", 64'({busy_o, done_o, error_o, err_addr_o, err_cnt_o}), 64'(0));
    rst_ni = 1'b1;

    launch(MODE_FILL, 32'hA5A5_0000, 0, e0);
    wait_done(1'b0, 1'b0);
    check("ram_word3", 64'(ram[3]), 64'(32'hA5A5_0003));

    launch(MODE_FILL_CHECK, 32'hFFFF_FFFF, 0, e0);
    wait_done(1'b0, 1'b0);

    corrupt[5] = 1'b1;
    corrupt[9] = 1'b1;
    launch(MODE_FILL_CHECK, 32'hFFFF_FFFF, 0, e0);
    wait_done(1'b0, 1'b0);
    launch(MODE_CHECK, 32'h1234_5678, 0, e0);
    wait_done(1'b0, 1'b0);

    launch(MODE_FILL, 32'h0F0F_F0F0, 6, e0);
    do @(negedge clk); while (cyc != e0 + 5);
    abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    check("abort_release", 64'({mem_csn, busy_o}), 64'({1'b1, 1'b0}));
    repeat (4) @(negedge clk);
    check("abort_acc_left", 64'(acc_q.size()), 64'(0));

    launch(MODE_FILL_CHECK, 32'hCAFE_0000, 0, e0);
    wait_done(1'b1, 1'b0);
    launch(2'b11, 32'h0000_BEEF, 0, e0);
    wait_done(1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 2**AW; a++) corrupt[a] = ($urandom_range(0, 3) == 0);
      launch(2'($urandom_range(0, 3)), $urandom, 0, e0);
      wait_done(1'b0, 1'b0);
    end

    launch(MODE_FILL_CHECK, 32'h5555_AAAA, 0, e0);
    do @(negedge clk); while (cyc != e0 + NW + 3);
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_bus", 64'({mem_csn, mem_wen, mem_be, mem_add, mem_wdata}),
          64'({1'b1, 1'b1, 4'h0, AW'(0), 32'h0}));
    check("rst_mid_status", 64'({busy_o, done_o, error_o, err_addr_o, err_cnt_o}), 64'(0));
    acc_q.delete();
    res_q.delete();
    @(negedge clk) rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'({busy_o, mem_csn}), 64'({1'b0, 1'b1}));

    wait (big_fin);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
